// File: rtl/tff_counter.sv
// Parametrised counter built as a bank of T flip-flops: each edge applies q <= q ^ t,
// where t is chosen per mode (toggle mask, modulo up/down, clamped load).
module tff_counter #(
   parameter int unsigned      WIDTH     = 4,
   parameter longint unsigned  MODULUS   = 16,
   parameter int unsigned      RESET_VAL = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] t_mask,
   input  logic [WIDTH-1:0] load_val,
   input  logic             clr_sticky,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             wrap,
   output logic             sticky_wrap
);

   localparam logic [1:0] MODE_TOGGLE = 2'b00;
   localparam logic [1:0] MODE_UP     = 2'b01;
   localparam logic [1:0] MODE_DOWN   = 2'b10;
   localparam logic [1:0] MODE_LOAD   = 2'b11;

   localparam logic [WIDTH-1:0] MAXV  = WIDTH'(MODULUS - 64'd1);
   localparam logic [WIDTH-1:0] RSTV  = WIDTH'(RESET_VAL);
   localparam bit               FULL  = (MODULUS == (64'd1 << WIDTH));

   logic [WIDTH-1:0] t;
   logic [WIDTH-1:0] up_t;
   logic [WIDTH-1:0] dn_t;
   logic [WIDTH-1:0] ld_v;
   logic             q_over;
   logic             ld_over;
   logic             q_top;
   logic             q_zero;
   logic             wrap_event;

   // A full-range modulus can never be exceeded, so the range checks vanish.
   if (FULL) begin : g_full
      assign q_over  = 1'b0;
      assign ld_over = 1'b0;
   end else begin : g_part
      assign q_over  = (q > MAXV);
      assign ld_over = (load_val > MAXV);
   end

   assign q_top  = (q >= MAXV);
   assign q_zero = (q == '0);

   // Bit i toggles when all lower bits are 1 (up) or all 0 (down): the increment/decrement XOR.
   assign up_t = q ^ (q + WIDTH'(1));
   assign dn_t = q ^ (q - WIDTH'(1));
   assign ld_v = ld_over ? MAXV : load_val;

   always_comb begin
      t = '0;
      if (en) begin
         case (mode)
            MODE_TOGGLE: t = t_mask;
            MODE_UP:     t = q_top ? q : up_t;
            MODE_DOWN:   t = (q_zero || q_over) ? (q ^ MAXV) : dn_t;
            MODE_LOAD:   t = q ^ ld_v;
            default:     t = '0;
         endcase
      end
   end

   assign wrap_event = en && (((mode == MODE_UP) && q_top) || ((mode == MODE_DOWN) && q_zero));
   assign tc         = wrap_event && !rst;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q           <= RSTV;
         wrap        <= 1'b0;
         sticky_wrap <= 1'b0;
      end else begin
         q           <= q ^ t;
         wrap        <= wrap_event;
         sticky_wrap <= (sticky_wrap && !clr_sticky) || wrap_event;
      end
   end

endmodule

// File: tb/tb_tff_counter.sv
// Bench for tff_counter: directed vectors drive two instances (4-bit mod 10 and 8-bit mod 256);
// expected observations go into a queue that a negedge monitor pops and compares.
module tb_tff_counter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;

   logic       a_en, a_clr, a_tc, a_wrap, a_sticky;
   logic [1:0] a_mode;
   logic [3:0] a_mask, a_ld, a_q;

   logic       b_en, b_clr, b_tc, b_wrap, b_sticky;
   logic [1:0] b_mode;
   logic [7:0] b_mask, b_ld, b_q;

   // Entry layout: {sel, q[7:0], tc, wrap, sticky_wrap}; sel=1 selects the 8-bit instance.
   logic [11:0] exp_q[$];
   int          checks = 0;
   int          errors = 0;
   int          step   = 0;

   tff_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) dut_a (
      .clk(clk), .rst(rst), .en(a_en), .mode(a_mode), .t_mask(a_mask), .load_val(a_ld),
      .clr_sticky(a_clr), .q(a_q), .tc(a_tc), .wrap(a_wrap), .sticky_wrap(a_sticky)
   );

   tff_counter #(.WIDTH(8), .MODULUS(256), .RESET_VAL(0)) dut_b (
      .clk(clk), .rst(rst), .en(b_en), .mode(b_mode), .t_mask(b_mask), .load_val(b_ld),
      .clr_sticky(b_clr), .q(b_q), .tc(b_tc), .wrap(b_wrap), .sticky_wrap(b_sticky)
   );

   always #5 clk = ~clk;

   // Apply inputs just after a rising edge and record what the monitor must see before the next edge.
   task automatic drv(input logic sel, input logic r, input logic e, input logic [1:0] m,
                      input logic [7:0] mask, input logic [7:0] ld, input logic clr,
                      input logic [7:0] eq, input logic etc, input logic ew, input logic es);
      rst    = r;
      a_en   = e & ~sel;
      a_mode = m;
      a_mask = mask[3:0];
      a_ld   = ld[3:0];
      a_clr  = clr & ~sel;
      b_en   = e & sel;
      b_mode = m;
      b_mask = mask;
      b_ld   = ld;
      b_clr  = clr & sel;
      exp_q.push_back({sel, eq, etc, ew, es});
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL step %0d %s: got %0d expected %0d", step, name, act, exp);
      end
   endtask

   initial begin : monitor
      logic [11:0] e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e[11]) begin
               chk("b_q", b_q, e[10:3]);
               chk("b_tc", {7'd0, b_tc}, {7'd0, e[2]});
               chk("b_wrap", {7'd0, b_wrap}, {7'd0, e[1]});
               chk("b_sticky", {7'd0, b_sticky}, {7'd0, e[0]});
            end else begin
               chk("a_q", {4'd0, a_q}, e[10:3]);
               chk("a_tc", {7'd0, a_tc}, {7'd0, e[2]});
               chk("a_wrap", {7'd0, a_wrap}, {7'd0, e[1]});
               chk("a_sticky", {7'd0, a_sticky}, {7'd0, e[0]});
            end
            step++;
         end
      end
   end

   initial begin : stimulus
      a_en = 0; a_mode = 0; a_mask = 0; a_ld = 0; a_clr = 0;
      b_en = 0; b_mode = 0; b_mask = 0; b_ld = 0; b_clr = 0;
      @(posedge clk);
      #1;
      // Reset held: q at reset value and tc masked even with a down-count at zero requested.
      drv(0, 1, 1, 2'b10, 0, 0, 0,   0, 0, 0, 0);
      // Up-count through the 9 -> 0 wrap.
      drv(0, 0, 1, 2'b01, 0, 0, 0,   0, 0, 0, 0);
      for (int k = 1; k <= 8; k++)
         drv(0, 0, 1, 2'b01, 0, 0, 0, 8'(k), 0, 0, 0);
      drv(0, 0, 1, 2'b01, 0, 0, 0,   9, 1, 0, 0);
      drv(0, 0, 1, 2'b01, 0, 0, 0,   0, 0, 1, 1);
      drv(0, 0, 1, 2'b01, 0, 0, 0,   1, 0, 0, 1);
      // Load 0, then down-count through the 0 -> 9 wrap.
      drv(0, 0, 1, 2'b11, 0, 0, 0,   2, 0, 0, 1);
      drv(0, 0, 1, 2'b10, 0, 0, 0,   0, 1, 0, 1);
      drv(0, 0, 1, 2'b10, 0, 0, 0,   9, 0, 1, 1);
      drv(0, 0, 1, 2'b10, 0, 0, 0,   8, 0, 0, 1);
      // Toggle mask, out-of-range up wrap, down resync.
      drv(0, 0, 1, 2'b11, 0, 0, 0,   7, 0, 0, 1);
      drv(0, 0, 1, 2'b00, 5, 0, 0,   0, 0, 0, 1);
      drv(0, 0, 1, 2'b00, 5, 0, 0,   5, 0, 0, 1);
      drv(0, 0, 1, 2'b00, 15, 0, 0,  0, 0, 0, 1);
      drv(0, 0, 1, 2'b01, 0, 0, 0,   15, 1, 0, 1);
      drv(0, 0, 1, 2'b00, 15, 0, 0,  0, 0, 1, 1);
      drv(0, 0, 1, 2'b10, 0, 0, 0,   15, 0, 0, 1);
      // Load, clamp, enable low.
      drv(0, 0, 1, 2'b11, 0, 7, 0,   9, 0, 0, 1);
      drv(0, 0, 1, 2'b11, 0, 12, 0,  7, 0, 0, 1);
      drv(0, 0, 0, 2'b01, 0, 0, 0,   9, 0, 0, 1);
      drv(0, 0, 0, 2'b01, 0, 0, 0,   9, 0, 0, 1);
      drv(0, 0, 0, 2'b01, 0, 0, 0,   9, 0, 0, 1);
      // Async reset mid-cycle at q=6 is visible before the next edge.
      drv(0, 0, 1, 2'b11, 0, 5, 0,   9, 0, 0, 1);
      drv(0, 0, 1, 2'b01, 0, 0, 0,   5, 0, 0, 1);
      drv(0, 1, 1, 2'b01, 0, 0, 0,   0, 0, 0, 0);
      drv(0, 0, 1, 2'b01, 0, 0, 0,   0, 0, 0, 0);
      drv(0, 0, 1, 2'b01, 0, 0, 0,   1, 0, 0, 0);
      // Clear on the wrapping edge loses to the set; clear on the following edge wins.
      drv(0, 0, 1, 2'b11, 0, 8, 0,   2, 0, 0, 0);
      drv(0, 0, 1, 2'b01, 0, 0, 0,   8, 0, 0, 0);
      drv(0, 0, 1, 2'b01, 0, 0, 1,   9, 1, 0, 0);
      drv(0, 0, 1, 2'b01, 0, 0, 1,   0, 0, 1, 1);
      drv(0, 0, 1, 2'b01, 0, 0, 0,   1, 0, 0, 0);
      // Clear still honoured with enable low.
      drv(0, 0, 1, 2'b11, 0, 9, 0,   2, 0, 0, 0);
      drv(0, 0, 1, 2'b01, 0, 0, 0,   9, 1, 0, 0);
      drv(0, 0, 0, 2'b01, 0, 0, 1,   0, 0, 1, 1);
      drv(0, 0, 0, 2'b01, 0, 0, 0,   0, 0, 0, 0);
      // 8-bit full-range instance: natural overflow both ways.
      drv(1, 0, 1, 2'b11, 0, 254, 0, 0, 0, 0, 0);
      drv(1, 0, 1, 2'b01, 0, 0, 0,   254, 0, 0, 0);
      drv(1, 0, 1, 2'b01, 0, 0, 0,   255, 1, 0, 0);
      drv(1, 0, 1, 2'b01, 0, 0, 0,   0, 0, 1, 1);
      drv(1, 0, 1, 2'b10, 0, 0, 0,   1, 0, 0, 1);
      drv(1, 0, 1, 2'b10, 0, 0, 0,   0, 1, 0, 1);
      drv(1, 0, 1, 2'b00, 0, 0, 0,   255, 0, 1, 1);

      for (int i = 0; i < 10; i++) begin
         if (exp_q.size() == 0) break;
         @(posedge clk);
      end
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: got %0d pending entries expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
